// File: rtl/ext_mem_arbiter_pkg.sv
// Shared constants for the external memory arbiter: default widths,
// FSM state encodings and requester port IDs.
package ext_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned LINE_W_DEF      = 256;
  localparam int unsigned TIMEOUT_CYC_DEF = 1023;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Requester port IDs
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/ext_mem_arbiter_if.sv
// Bus bundle between the two L1 controllers, the arbiter and the external
// memory port.
//   i_* / d_*   : requester handshake (cs/we/addr/wdata in, ack/rdata out)
//   ext_mem_*   : single shared memory port
// slave  : arbiter view
// master : environment view (controllers + memory)
interface ext_mem_arbiter_if
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
);

  logic              i_cs;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_wdata;
  logic              i_ack;
  logic [LINE_W-1:0] i_rdata;

  logic              d_cs;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_ack;
  logic [LINE_W-1:0] d_rdata;

  logic              ext_mem_cs;
  logic              ext_mem_we;
  logic [ADDR_W-1:0] ext_mem_addr;
  logic [LINE_W-1:0] ext_mem_data_o;
  logic [LINE_W-1:0] ext_mem_data_i;
  logic              ext_mem_ack;

  modport slave (
    input  i_cs, i_we, i_addr, i_wdata,
    output i_ack, i_rdata,
    input  d_cs, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output ext_mem_cs, ext_mem_we, ext_mem_addr, ext_mem_data_o,
    input  ext_mem_data_i, ext_mem_ack
  );

  modport master (
    output i_cs, i_we, i_addr, i_wdata,
    input  i_ack, i_rdata,
    output d_cs, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  ext_mem_cs, ext_mem_we, ext_mem_addr, ext_mem_data_o,
    output ext_mem_data_i, ext_mem_ack
  );

endinterface

// File: rtl/ext_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   req_i, req_d  : request lines
//   last_grant    : side granted most recently (PORT_I / PORT_D)
//   gnt_valid_c   : at least one side is requesting
//   gnt_side_c    : side to grant; on a tie, the side not granted last
module rr_arb2
  import ext_mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid_c,
  output logic gnt_side_c
);

  always_comb begin
    gnt_valid_c = req_i | req_d;
    gnt_side_c  = PORT_I;
    if (req_i && req_d) begin
      gnt_side_c = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      gnt_side_c = PORT_D;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares the single external memory line port between the
// I-side and D-side L1 controllers. Round-robin grant held for a whole
// transaction, one-cycle ack pulse to the winner, sticky watchdog timeout.
//   clk     : clock, all logic on posedge
//   rst     : synchronous active-high reset
//   bus     : requester and memory handshakes (slave modport)
//   timeout : sticky, a transaction waited TIMEOUT_CYC BUSY cycles unacked
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned LINE_W      = LINE_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ext_mem_arbiter_if.slave    bus,
  output logic                timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]        state_q,      state_nxt;
  logic              last_grant_q, last_grant_nxt;
  logic [CNT_W-1:0]  wd_cnt_q,     wd_cnt_nxt;
  logic [CNT_W-1:0]  wd_cnt_inc_c;
  logic              mem_cs_q,     mem_cs_nxt;
  logic              mem_we_q,     mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_nxt;
  logic [LINE_W-1:0] mem_wdata_q,  mem_wdata_nxt;
  logic              i_ack_q,      i_ack_nxt;
  logic              d_ack_q,      d_ack_nxt;
  logic [LINE_W-1:0] i_rdata_q,    i_rdata_nxt;
  logic [LINE_W-1:0] d_rdata_q,    d_rdata_nxt;
  logic              timeout_q,    timeout_nxt;

  logic gnt_valid_c;
  logic gnt_side_c;

  rr_arb2 u_rr_arb2 (
    .req_i       (bus.i_cs),
    .req_d       (bus.d_cs),
    .last_grant  (last_grant_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_side_c  (gnt_side_c)
  );

  assign wd_cnt_inc_c = wd_cnt_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state_q;
    last_grant_nxt = last_grant_q;
    wd_cnt_nxt     = wd_cnt_q;
    mem_cs_nxt     = mem_cs_q;
    mem_we_nxt     = mem_we_q;
    mem_addr_nxt   = mem_addr_q;
    mem_wdata_nxt  = mem_wdata_q;
    i_ack_nxt      = 1'b0;
    d_ack_nxt      = 1'b0;
    i_rdata_nxt    = i_rdata_q;
    d_rdata_nxt    = d_rdata_q;
    timeout_nxt    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        wd_cnt_nxt = '0;
        if (gnt_valid_c) begin
          state_nxt      = ST_BUSY;
          last_grant_nxt = gnt_side_c;
          mem_cs_nxt     = 1'b1;
          if (gnt_side_c == PORT_D) begin
            mem_we_nxt    = bus.d_we;
            mem_addr_nxt  = bus.d_addr;
            mem_wdata_nxt = bus.d_wdata;
          end else begin
            mem_we_nxt    = bus.i_we;
            mem_addr_nxt  = bus.i_addr;
            mem_wdata_nxt = bus.i_wdata;
          end
        end
      end

      ST_BUSY: begin
        // Ack takes priority over the watchdog expiring in the same cycle
        if (bus.ext_mem_ack) begin
          state_nxt  = ST_RESP;
          mem_cs_nxt = 1'b0;
          if (last_grant_q == PORT_D) begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = bus.ext_mem_data_i;
          end else begin
            i_ack_nxt   = 1'b1;
            i_rdata_nxt = bus.ext_mem_data_i;
          end
        end else if (wd_cnt_inc_c == CNT_W'(TIMEOUT_CYC)) begin
          // Abandon the transaction; the requester is left stalled
          state_nxt   = ST_IDLE;
          mem_cs_nxt  = 1'b0;
          timeout_nxt = 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt_inc_c;
        end
      end

      ST_RESP: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt  = ST_IDLE;
        mem_cs_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_I;
      wd_cnt_q     <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      last_grant_q <= last_grant_nxt;
      wd_cnt_q     <= wd_cnt_nxt;
      mem_cs_q     <= mem_cs_nxt;
      mem_we_q     <= mem_we_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_wdata_q  <= mem_wdata_nxt;
      i_ack_q      <= i_ack_nxt;
      d_ack_q      <= d_ack_nxt;
      i_rdata_q    <= i_rdata_nxt;
      d_rdata_q    <= d_rdata_nxt;
      timeout_q    <= timeout_nxt;
    end
  end

  assign bus.ext_mem_cs     = mem_cs_q;
  assign bus.ext_mem_we     = mem_we_q;
  assign bus.ext_mem_addr   = mem_addr_q;
  assign bus.ext_mem_data_o = mem_wdata_q;
  assign bus.i_ack          = i_ack_q;
  assign bus.d_ack          = d_ack_q;
  assign bus.i_rdata        = i_rdata_q;
  assign bus.d_rdata        = d_rdata_q;
  assign timeout            = timeout_q;

endmodule
